// File: rtl/alu_ctrl_mux_pkg.sv
// rtl/alu_ctrl_mux_pkg.sv - shared constants and types for the ALU / control / operand mux slice
//
// Purpose : opcode encodings, ALU operation encodings, the default datapath
//           width and the decoded-control bundle used by alu_ctrl_mux.
// Ports   : none (package).

package alu_ctrl_mux_pkg;

    // Default datapath width for operands and results.
    localparam int DEFAULT_WIDTH = 32;

    // Width of the immediate field carried in INSTRUCTION[4:0].
    localparam int IMM_BITS = 5;

    // Opcode encodings, INSTRUCTION[18:15].
    localparam logic [3:0] OP_LOADI = 4'b0000;
    localparam logic [3:0] OP_MOV   = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_OR    = 4'b0101;
    localparam logic [3:0] OP_XOR   = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_ADDI  = 4'b1001;
    localparam logic [3:0] OP_SUBI  = 4'b1010;
    localparam logic [3:0] OP_BRZ   = 4'b1011;
    localparam logic [3:0] OP_BRNZ  = 4'b1100;
    localparam logic [3:0] OP_JMP   = 4'b1101;
    localparam logic [3:0] OP_ANDI  = 4'b1110;
    localparam logic [3:0] OP_NOP   = 4'b1111;

    // ALU operation encodings.
    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    // Decoded control bundle produced by the opcode decoder.
    typedef struct packed {
        logic [2:0] aluop;
        logic       imm_select;
        logic       write_enable;
        logic       braz;
        logic       branz;
        logic       brauncond;
    } ctrl_t;

    // Builds a control bundle; keeps the decoder table one line per opcode.
    function automatic ctrl_t make_ctrl(
        input logic [2:0] aluop,
        input logic       imm_select,
        input logic       write_enable,
        input logic       braz,
        input logic       branz,
        input logic       brauncond
    );
        ctrl_t c;
        c.aluop        = aluop;
        c.imm_select   = imm_select;
        c.write_enable = write_enable;
        c.braz         = braz;
        c.branz        = branz;
        c.brauncond    = brauncond;
        return c;
    endfunction

endpackage

// File: rtl/alu_ctrl_mux_mux32.sv
// rtl/alu_ctrl_mux_mux32.sv - WIDTH-wide 2:1 multiplexer used for the ALU operand-B select
//
// Purpose : SEL=0 passes IN0, SEL=1 passes IN1. Purely combinational.
// Ports   : IN0  [WIDTH-1:0] input  - selected when SEL=0
//           IN1  [WIDTH-1:0] input  - selected when SEL=1
//           SEL               input  - select
//           OUT  [WIDTH-1:0] output - selected data

module mux32 #(
    parameter int WIDTH = alu_ctrl_mux_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] IN0,
    input  logic [WIDTH-1:0] IN1,
    input  logic             SEL,
    output logic [WIDTH-1:0] OUT
);

    assign OUT = SEL ? IN1 : IN0;

endmodule

// File: rtl/alu_ctrl_mux.sv
// rtl/alu_ctrl_mux.sv - opcode decoder, operand-B mux, ALU and branch-taken logic with registered result
//
// Purpose : decodes OPCODE into ALU/branch control, selects operand B between
//           OPERAND2 and the zero-extended immediate, computes the ALU result
//           and zero flag combinationally, resolves the PC-select, and keeps a
//           one-cycle registered copy of the result and zero flag.
// Ports   : CLK                       input  - clock, rising edge
//           RESET                     input  - synchronous active-high reset
//           OPCODE       [3:0]        input  - INSTRUCTION[18:15]
//           OPERAND1     [WIDTH-1:0]  input  - ALU operand A
//           OPERAND2     [WIDTH-1:0]  input  - operand-B mux input 0
//           IMM5         [4:0]        input  - INSTRUCTION[4:0]
//           ALU_OUT      [WIDTH-1:0]  output - combinational ALU result
//           ZERO                      output - ALU_OUT == 0
//           WRITE_ENABLE              output - register-file write enable
//           TAKEN                     output - 1 selects JUMP_TARGET for the PC
//           JUMP_TARGET  [WIDTH-1:0]  output - IMM5 zero-extended
//           ALU_OUT_Q    [WIDTH-1:0]  output - ALU_OUT registered
//           ZERO_Q                    output - ZERO registered

module alu_ctrl_mux #(
    parameter int WIDTH = alu_ctrl_mux_pkg::DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [3:0]       OPCODE,
    input  logic [WIDTH-1:0] OPERAND1,
    input  logic [WIDTH-1:0] OPERAND2,
    input  logic [4:0]       IMM5,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic             ZERO,
    output logic             WRITE_ENABLE,
    output logic             TAKEN,
    output logic [WIDTH-1:0] JUMP_TARGET,
    output logic [WIDTH-1:0] ALU_OUT_Q,
    output logic             ZERO_Q
);

    import alu_ctrl_mux_pkg::*;

    ctrl_t            ctrl;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] operand_b;
    logic [4:0]       shamt;

    // Immediate is zero-extended, never sign-extended.
    assign imm         = {{(WIDTH - IMM_BITS){1'b0}}, IMM5};
    assign JUMP_TARGET = imm;

    // ------------------------------------------------------------------
    // Opcode decoder
    // ------------------------------------------------------------------
    always_comb begin
        ctrl = make_ctrl(ALU_FWD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        case (OPCODE)
            //                          aluop    imm   we    braz  branz uncond
            OP_LOADI: ctrl = make_ctrl(ALU_FWD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            OP_MOV:   ctrl = make_ctrl(ALU_FWD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            OP_ADD:   ctrl = make_ctrl(ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            OP_SUB:   ctrl = make_ctrl(ALU_SUB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            OP_AND:   ctrl = make_ctrl(ALU_AND, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            OP_OR:    ctrl = make_ctrl(ALU_OR,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            OP_XOR:   ctrl = make_ctrl(ALU_XOR, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            OP_SLL:   ctrl = make_ctrl(ALU_SLL, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            OP_SRL:   ctrl = make_ctrl(ALU_SRL, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            OP_ADDI:  ctrl = make_ctrl(ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            OP_SUBI:  ctrl = make_ctrl(ALU_SUB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            // Conditional branches compare A and B by subtraction; ZERO means equal.
            OP_BRZ:   ctrl = make_ctrl(ALU_SUB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            OP_BRNZ:  ctrl = make_ctrl(ALU_SUB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            OP_JMP:   ctrl = make_ctrl(ALU_FWD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            OP_ANDI:  ctrl = make_ctrl(ALU_AND, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            OP_NOP:   ctrl = make_ctrl(ALU_FWD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            default:  ctrl = make_ctrl(ALU_FWD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        endcase
    end

    assign WRITE_ENABLE = ctrl.write_enable;

    // ------------------------------------------------------------------
    // Operand-B select
    // ------------------------------------------------------------------
    mux32 #(
        .WIDTH (WIDTH)
    ) u_operand_b_mux (
        .IN0 (OPERAND2),
        .IN1 (imm),
        .SEL (ctrl.imm_select),
        .OUT (operand_b)
    );

    // Shift distance uses only the low five bits of B.
    assign shamt = operand_b[4:0];

    // ------------------------------------------------------------------
    // ALU (modulo 2^WIDTH, carry/borrow discarded)
    // ------------------------------------------------------------------
    always_comb begin
        ALU_OUT = operand_b;
        case (ctrl.aluop)
            ALU_FWD: ALU_OUT = operand_b;
            ALU_ADD: ALU_OUT = OPERAND1 + operand_b;
            ALU_SUB: ALU_OUT = OPERAND1 - operand_b;
            ALU_AND: ALU_OUT = OPERAND1 & operand_b;
            ALU_OR:  ALU_OUT = OPERAND1 | operand_b;
            ALU_XOR: ALU_OUT = OPERAND1 ^ operand_b;
            ALU_SLL: ALU_OUT = OPERAND1 << shamt;
            ALU_SRL: ALU_OUT = OPERAND1 >> shamt;
            default: ALU_OUT = operand_b;
        endcase
    end

    assign ZERO  = (ALU_OUT == '0);
    assign TAKEN = (ctrl.braz & ZERO) | (ctrl.branz & ~ZERO) | ctrl.brauncond;

    // ------------------------------------------------------------------
    // Registered result; reset value mirrors a zero result (ZERO_Q=1).
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ALU_OUT_Q <= '0;
            ZERO_Q    <= 1'b1;
        end else begin
            ALU_OUT_Q <= ALU_OUT;
            ZERO_Q    <= ZERO;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_mux.sv
// tb/tb_alu_ctrl_mux.sv - directed self-checking bench for alu_ctrl_mux

module tb_alu_ctrl_mux;

    logic        CLK;
    logic        RESET;
    logic [3:0]  OPCODE;
    logic [31:0] OPERAND1;
    logic [31:0] OPERAND2;
    logic [4:0]  IMM5;
    logic [31:0] ALU_OUT;
    logic        ZERO;
    logic        WRITE_ENABLE;
    logic        TAKEN;
    logic [31:0] JUMP_TARGET;
    logic [31:0] ALU_OUT_Q;
    logic        ZERO_Q;

    int errors = 0;
    int checks = 0;

    alu_ctrl_mux #(
        .WIDTH (32)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .OPCODE       (OPCODE),
        .OPERAND1     (OPERAND1),
        .OPERAND2     (OPERAND2),
        .IMM5         (IMM5),
        .ALU_OUT      (ALU_OUT),
        .ZERO         (ZERO),
        .WRITE_ENABLE (WRITE_ENABLE),
        .TAKEN        (TAKEN),
        .JUMP_TARGET  (JUMP_TARGET),
        .ALU_OUT_Q    (ALU_OUT_Q),
        .ZERO_Q       (ZERO_Q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a vector away from the rising edge and let combinational outputs settle.
    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] imm);
        @(negedge CLK);
        OPCODE   = op;
        OPERAND1 = a;
        OPERAND2 = b;
        IMM5     = imm;
        #1;
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET    = 1'b1;
        OPCODE   = 4'b1111;
        OPERAND1 = '0;
        OPERAND2 = '0;
        IMM5     = '0;

        // Reset state
        tick();
        chk("reset_alu_out_q", ALU_OUT_Q, 32'h0);
        chk("reset_zero_q", {31'b0, ZERO_Q}, 32'h1);
        RESET = 1'b0;

        // ADD 5+7
        apply(4'b0010, 32'd5, 32'd7, 5'd0);
        chk("add_alu_out", ALU_OUT, 32'd12);
        chk("add_zero", {31'b0, ZERO}, 32'h0);
        chk("add_we", {31'b0, WRITE_ENABLE}, 32'h1);
        chk("add_taken", {31'b0, TAKEN}, 32'h0);
        tick();
        chk("add_alu_out_q", ALU_OUT_Q, 32'd12);
        chk("add_zero_q", {31'b0, ZERO_Q}, 32'h0);

        // SUB equal operands and wrap-around
        apply(4'b0011, 32'd9, 32'd9, 5'd0);
        chk("sub_eq_alu_out", ALU_OUT, 32'h0);
        chk("sub_eq_zero", {31'b0, ZERO}, 32'h1);
        tick();
        chk("sub_eq_zero_q", {31'b0, ZERO_Q}, 32'h1);
        apply(4'b0011, 32'd0, 32'd1, 5'd0);
        chk("sub_wrap_alu_out", ALU_OUT, 32'hFFFF_FFFF);
        chk("sub_wrap_zero", {31'b0, ZERO}, 32'h0);

        // BRZ / BRNZ with A=B=3
        apply(4'b1011, 32'd3, 32'd3, 5'd17);
        chk("brz_taken", {31'b0, TAKEN}, 32'h1);
        chk("brz_target", JUMP_TARGET, 32'd17);
        chk("brz_we", {31'b0, WRITE_ENABLE}, 32'h0);
        apply(4'b1100, 32'd3, 32'd3, 5'd17);
        chk("brnz_taken_eq", {31'b0, TAKEN}, 32'h0);
        apply(4'b1100, 32'd3, 32'd4, 5'd17);
        chk("brnz_taken_ne", {31'b0, TAKEN}, 32'h1);
        apply(4'b1011, 32'd3, 32'd4, 5'd17);
        chk("brz_taken_ne", {31'b0, TAKEN}, 32'h0);

        // LOADI zero-extension; JMP regardless of ZERO
        apply(4'b0000, 32'hDEAD_BEEF, 32'h1234_5678, 5'd31);
        chk("loadi_alu_out", ALU_OUT, 32'd31);
        chk("loadi_we", {31'b0, WRITE_ENABLE}, 32'h1);
        apply(4'b1101, 32'd0, 32'd0, 5'd4);
        chk("jmp_taken", {31'b0, TAKEN}, 32'h1);
        chk("jmp_target", JUMP_TARGET, 32'd4);
        chk("jmp_we", {31'b0, WRITE_ENABLE}, 32'h0);
        apply(4'b1101, 32'd0, 32'd0, 5'd0);
        chk("jmp_taken_zero", {31'b0, TAKEN}, 32'h1);
        chk("jmp_zero", {31'b0, ZERO}, 32'h1);

        // Shifts and XOR
        apply(4'b0111, 32'd1, 32'hFFFF_FFFF, 5'd31);
        chk("sll_31", ALU_OUT, 32'h8000_0000);
        apply(4'b1000, 32'h8000_0000, 32'd0, 5'd31);
        chk("srl_31", ALU_OUT, 32'h1);
        apply(4'b0111, 32'hA5A5_0F0F, 32'd7, 5'd0);
        chk("sll_0", ALU_OUT, 32'hA5A5_0F0F);
        apply(4'b0110, 32'h1357_9BDF, 32'h1357_9BDF, 5'd0);
        chk("xor_eq_alu_out", ALU_OUT, 32'h0);
        chk("xor_eq_zero", {31'b0, ZERO}, 32'h1);

        // Remaining decode rows
        apply(4'b0001, 32'd1, 32'hCAFE_0001, 5'd9);
        chk("mov_alu_out", ALU_OUT, 32'hCAFE_0001);
        apply(4'b0100, 32'hF0F0_FFFF, 32'h0FF0_00FF, 5'd0);
        chk("and_alu_out", ALU_OUT, 32'h00F0_00FF);
        apply(4'b0101, 32'hF000_0000, 32'h0000_000F, 5'd0);
        chk("or_alu_out", ALU_OUT, 32'hF000_000F);
        apply(4'b1001, 32'hFFFF_FFF0, 32'd999, 5'd16);
        chk("addi_wrap", ALU_OUT, 32'h0);
        chk("addi_zero", {31'b0, ZERO}, 32'h1);
        apply(4'b1010, 32'd100, 32'd999, 5'd30);
        chk("subi_alu_out", ALU_OUT, 32'd70);
        apply(4'b1110, 32'hFFFF_FFFF, 32'd0, 5'd21);
        chk("andi_alu_out", ALU_OUT, 32'd21);
        apply(4'b1111, 32'd5, 32'd6, 5'd7);
        chk("nop_alu_out", ALU_OUT, 32'd6);
        chk("nop_we", {31'b0, WRITE_ENABLE}, 32'h0);
        chk("nop_taken", {31'b0, TAKEN}, 32'h0);

        // Mid-stream reset overrides load; combinational path unaffected
        apply(4'b0010, 32'd5, 32'd7, 5'd0);
        tick();
        chk("pre_reset_q", ALU_OUT_Q, 32'd12);
        RESET = 1'b1;
        tick();
        chk("midreset_alu_out_q", ALU_OUT_Q, 32'h0);
        chk("midreset_zero_q", {31'b0, ZERO_Q}, 32'h1);
        chk("midreset_alu_out", ALU_OUT, 32'd12);
        chk("midreset_zero", {31'b0, ZERO}, 32'h0);
        RESET = 1'b0;
        tick();
        chk("post_reset_q", ALU_OUT_Q, 32'd12);
        chk("post_reset_zero_q", {31'b0, ZERO_Q}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_mux.md
ALU_CTRL_MUX -- requirements
Module: alu_ctrl_mux

Interface
REQ-001 Parameter WIDTH, default 32: datapath width of operands and results.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 CLK  input  1  clock; all state updates on its rising edge.
REQ-004 RESET  input  1  synchronous active-high reset.
REQ-005 OPCODE  input  4  instruction opcode, INSTRUCTION[18:15].
REQ-006 OPERAND1  input  WIDTH  register-file read data 1, ALU operand A.
REQ-007 OPERAND2  input  WIDTH  register-file read data 2, mux input 0.
REQ-008 IMM5  input  5  immediate field, INSTRUCTION[4:0].
REQ-009 ALU_OUT  output  WIDTH  combinational ALU result.
REQ-010 ZERO  output  1  combinational: 1 when ALU_OUT == 0.
REQ-011 WRITE_ENABLE  output  1  combinational register-file write enable.
REQ-012 TAKEN  output  1  combinational PC-select: 1 selects JUMP_TARGET.
REQ-013 JUMP_TARGET  output  WIDTH  IMM5 zero-extended to WIDTH.
REQ-014 ALU_OUT_Q, ZERO_Q  output  WIDTH, 1  ALU_OUT and ZERO registered on CLK.

Function
REQ-015 Immediate: IMM = {(WIDTH-5) zeros, IMM5}; there is no sign extension.
REQ-016 Control signals are combinational: ALUOP[2:0], WRITE_ENABLE, IMM_SELECT, BRAZ, BRANZ, BRAUNCOND.
REQ-017 Operand B mux: IMM_SELECT=0 -> OPERAND2; IMM_SELECT=1 -> IMM.
REQ-018 ALUOP: 000 FWD (B), 001 ADD (A+B), 010 SUB (A-B), 011 AND, 100 OR, 101 XOR, 110 SLL (A<<B[4:0]), 111 SRL (A>>B[4:0], logical).
REQ-019 Arithmetic is modulo 2^WIDTH; carry and borrow are discarded; there is no overflow flag.
REQ-020 Opcode table, listed as op: ALUOP, IMM_SELECT, WRITE_ENABLE, branch:
- 0000 LOADI: FWD, 1, 1
- 0001 MOV: FWD, 0, 1
- 0010 ADD: ADD, 0, 1
- 0011 SUB: SUB, 0, 1
- 0100 AND: AND, 0, 1
- 0101 OR: OR, 0, 1
- 0110 XOR: XOR, 0, 1
- 0111 SLL: SLL, 1, 1
- 1000 SRL: SRL, 1, 1
- 1001 ADDI: ADD, 1, 1
- 1010 SUBI: SUB, 1, 1
- 1011 BRZ: SUB, 0, 0, BRAZ=1
- 1100 BRNZ: SUB, 0, 0, BRANZ=1
- 1101 JMP: FWD, 1, 0, BRAUNCOND=1
- 1110 ANDI: AND, 1, 1
- 1111 NOP: FWD, 0, 0
REQ-021 Branch flags (BRAZ, BRANZ, BRAUNCOND) are 0 for every opcode not marked in REQ-020.
REQ-022 TAKEN = (BRAZ & ZERO) | (BRANZ & ~ZERO) | BRAUNCOND.
REQ-023 Combinational paths have zero latency and no modelled delays; outputs settle in the same cycle the inputs change.
REQ-024 ALU_OUT_Q and ZERO_Q load ALU_OUT and ZERO on every rising edge when RESET=0, giving one cycle of latency.
REQ-025 A shift amount of 0 returns A unchanged; shift amounts are taken from B[4:0] only, and higher B bits are ignored.
REQ-026 Unknown (X/Z) opcodes are undefined; every defined opcode fully drives all outputs, so no latches are inferred.

Reset
REQ-027 When RESET=1 at a rising CLK edge: ALU_OUT_Q=0 and ZERO_Q=1, since this is consistent with a zero result.
REQ-028 Reset does not gate the combinational outputs; they keep following the inputs during reset.
REQ-029 RESET asserted mid-stream overrides the load on that edge.

Structure
REQ-030 A shared package holds:
- the opcode constants (REQ-020)
- the ALUOP constants (REQ-018)
- the default WIDTH
REQ-031 A single sub-module, mux32 (2:1, WIDTH-wide), is instantiated for the operand-B select.
REQ-032 The decoder and the ALU are implemented as separate combinational always blocks within alu_ctrl_mux.

Verification
REQ-033 ADD, 5+7 -> ALU_OUT=12, ZERO=0, WRITE_ENABLE=1, TAKEN=0; ALU_OUT_Q=12 after the next edge.
REQ-034 SUB with 9,9 -> ALU_OUT=0, ZERO=1; SUB with 0,1 -> ALU_OUT=0xFFFFFFFF, ZERO=0 (wrap-around).
REQ-035 BRZ with A=B=3, IMM5=17 -> TAKEN=1, JUMP_TARGET=17, WRITE_ENABLE=0; BRNZ with the same operands -> TAKEN=0.
REQ-036 LOADI, IMM5=31 -> ALU_OUT=31, so the immediate is zero-extended; JMP, IMM5=4 -> TAKEN=1 regardless of ZERO.
REQ-037 SLL, A=1, IMM5=31 -> 0x80000000; SRL, A=0x80000000, IMM5=31 -> 1; XOR with A=B -> 0, ZERO=1.
REQ-038 RESET=1 for one edge while an ADD producing 12 is applied -> ALU_OUT_Q=0 and ZERO_Q=1; ALU_OUT stays 12.
